// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, message kinds, allocator FSM states.
package midi_pkg;

    localparam logic [3:0] ST_NOTE_OFF      = 4'h8;
    localparam logic [3:0] ST_NOTE_ON       = 4'h9;
    localparam logic [3:0] ST_CTRL          = 4'hB;
    localparam logic [6:0] ALL_NOTES_OFF_CC = 7'd123;

    typedef enum logic [1:0] {MSG_NONE, MSG_ON, MSG_OFF, MSG_ALLOFF} msg_kind_t;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} fsm_state_t;

    typedef struct packed {
        logic [7:0] status;
        logic [7:0] d1;
        logic [7:0] d2;
    } midi_msg_t;

endpackage

// File: rtl/midi_msg_decode.sv
// Channel filter and message classification for a parsed 3-byte MIDI message.
module midi_msg_decode
    import midi_pkg::*;
#(
    parameter int CHANNEL = 0,
    parameter int OMNI    = 0
) (
    input  logic [7:0] i_status,
    input  logic [7:0] i_data1,
    input  logic [7:0] i_data2,
    output msg_kind_t  o_kind
);

    logic w_chan_ok;
    logic w_unused;

    assign w_chan_ok = (OMNI != 0) || (i_status[3:0] == 4'(CHANNEL));
    // Data bytes are 7-bit; the top bits carry no meaning here.
    assign w_unused  = ^{i_data1[7], i_data2[7]};

    always_comb begin
        o_kind = MSG_NONE;
        if (w_chan_ok) begin
            case (i_status[7:4])
                ST_NOTE_ON:  o_kind = (i_data2[6:0] != 7'd0) ? MSG_ON : MSG_OFF;
                ST_NOTE_OFF: o_kind = MSG_OFF;
                ST_CTRL:     if (i_data1[6:0] == ALL_NOTES_OFF_CC) o_kind = MSG_ALLOFF;
                default:     o_kind = MSG_NONE;
            endcase
        end
    end

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: one-deep message capture, per-voice scan, commit with LRU stealing.
module midi_voice_alloc
    import midi_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int CHANNEL    = 0,
    parameter int OMNI       = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [7:0]              i_midi_status,
    input  logic [7:0]              i_midi_data1,
    input  logic [7:0]              i_midi_data2,
    input  logic                    i_midi_msg_rdy,
    output logic [NUM_VOICES-1:0]   o_voice_gate,
    output logic [7*NUM_VOICES-1:0] o_voice_note,
    output logic [7*NUM_VOICES-1:0] o_voice_vel,
    output logic [NUM_VOICES-1:0]   o_voice_trig,
    output logic                    o_busy,
    output logic                    o_overflow
);

    localparam int             IW       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_VOICES - 1);

    fsm_state_t                       r_state, w_next;
    logic                             r_rdy_prev;
    logic                             r_pend_vld;
    midi_msg_t                        r_pend;
    logic                             r_overflow;
    msg_kind_t                        r_kind;
    logic [6:0]                       r_wnote, r_wvel;
    logic [IW-1:0]                    r_idx;
    logic                             r_match_found, r_free_found;
    logic [IW-1:0]                    r_match, r_free, r_oldest;
    logic [NUM_VOICES-1:0]            r_gate, r_trig;
    logic [NUM_VOICES-1:0][6:0]       r_note, r_vel;
    logic [NUM_VOICES-1:0][IW-1:0]    r_rank;

    msg_kind_t                        w_kind;
    logic                             w_rdy_rise;
    logic [IW-1:0]                    w_target;
    logic [IW-1:0]                    w_tgt_rank;

    midi_msg_decode #(.CHANNEL(CHANNEL), .OMNI(OMNI)) u_decode (
        .i_status (r_pend.status),
        .i_data1  (r_pend.d1),
        .i_data2  (r_pend.d2),
        .o_kind   (w_kind)
    );

    assign w_rdy_rise = i_midi_msg_rdy && !r_rdy_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (r_pend_vld && w_kind != MSG_NONE) w_next = S_SCAN;
            S_SCAN:   if (r_idx == LAST_IDX) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Target priority: same sounding note, then lowest free voice, then steal the oldest.
    always_comb begin
        w_target = r_oldest;
        if (r_match_found)     w_target = r_match;
        else if (r_free_found) w_target = r_free;
        w_tgt_rank = r_rank[w_target];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdy_prev    <= 1'b0;
            r_pend_vld    <= 1'b0;
            r_pend        <= '0;
            r_overflow    <= 1'b0;
            r_kind        <= MSG_NONE;
            r_wnote       <= '0;
            r_wvel        <= '0;
            r_idx         <= '0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_match       <= '0;
            r_free        <= '0;
            r_oldest      <= '0;
            r_gate        <= '0;
            r_trig        <= '0;
            r_note        <= '0;
            r_vel         <= '0;
            for (int v = 0; v < NUM_VOICES; v++) r_rank[v] <= IW'(v);
        end else begin
            r_rdy_prev <= i_midi_msg_rdy;
            r_trig     <= '0;

            if (w_rdy_rise) begin
                if (r_pend_vld) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_pend_vld <= 1'b1;
                    r_pend     <= '{status: i_midi_status, d1: i_midi_data1, d2: i_midi_data2};
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (r_pend_vld) begin
                        r_pend_vld    <= 1'b0;
                        r_kind        <= w_kind;
                        r_wnote       <= r_pend.d1[6:0];
                        r_wvel        <= r_pend.d2[6:0];
                        r_idx         <= '0;
                        r_match_found <= 1'b0;
                        r_free_found  <= 1'b0;
                        r_oldest      <= '0;
                    end
                end
                S_SCAN: begin
                    if (r_gate[r_idx] && r_note[r_idx] == r_wnote) begin
                        if (!r_match_found) begin
                            r_match_found <= 1'b1;
                            r_match       <= r_idx;
                        end
                        if (r_kind == MSG_OFF) r_gate[r_idx] <= 1'b0;
                    end
                    if (!r_gate[r_idx] && !r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free       <= r_idx;
                    end
                    if (r_rank[r_idx] == LAST_IDX) r_oldest <= r_idx;
                    r_idx <= r_idx + IW'(1);
                end
                S_COMMIT: begin
                    if (r_kind == MSG_ON) begin
                        r_gate[w_target] <= 1'b1;
                        r_trig[w_target] <= 1'b1;
                        r_note[w_target] <= r_wnote;
                        r_vel[w_target]  <= r_wvel;
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (IW'(v) == w_target)        r_rank[v] <= '0;
                            else if (r_rank[v] < w_tgt_rank) r_rank[v] <= r_rank[v] + IW'(1);
                        end
                    end else if (r_kind == MSG_ALLOFF) begin
                        r_gate <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_voice_gate = r_gate;
    assign o_voice_note = r_note;
    assign o_voice_vel  = r_vel;
    assign o_voice_trig = r_trig;
    assign o_busy       = (r_state != S_IDLE);
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Self-checking bench: channel-filtered and omni allocators driven side by side from a vector table.
module tb_midi_voice_alloc;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     st = '0, d1 = '0, d2 = '0;
    logic           rdy = 1'b0;

    logic [N-1:0]   gate0, trig0, gate1, trig1;
    logic [7*N-1:0] note0, vel0, note1, vel1;
    logic           busy0, ovf0, busy1, ovf1;

    int n_chk = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    midi_voice_alloc #(.NUM_VOICES(N), .CHANNEL(0), .OMNI(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_midi_status(st), .i_midi_data1(d1), .i_midi_data2(d2),
        .i_midi_msg_rdy(rdy), .o_voice_gate(gate0), .o_voice_note(note0), .o_voice_vel(vel0),
        .o_voice_trig(trig0), .o_busy(busy0), .o_overflow(ovf0)
    );

    midi_voice_alloc #(.NUM_VOICES(N), .CHANNEL(0), .OMNI(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_midi_status(st), .i_midi_data1(d1), .i_midi_data2(d2),
        .i_midi_msg_rdy(rdy), .o_voice_gate(gate1), .o_voice_note(note1), .o_voice_vel(vel1),
        .o_voice_trig(trig1), .o_busy(busy1), .o_overflow(ovf1)
    );

    typedef struct {
        logic [7:0] st, d1, d2;
        logic [3:0] gate, trig;
        int         v;
        logic [6:0] note, vel;
        logic [3:0] gate1, trig1;
    } vec_t;

    vec_t vecs[12];
    vec_t sb[$];

    function automatic vec_t mk(logic [7:0] s, logic [7:0] a, logic [7:0] b,
                                logic [3:0] g, logic [3:0] t, int v, logic [6:0] n,
                                logic [6:0] vl, logic [3:0] g1, logic [3:0] t1);
        vec_t r;
        r.st = s; r.d1 = a; r.d2 = b; r.gate = g; r.trig = t; r.v = v;
        r.note = n; r.vel = vl; r.gate1 = g1; r.trig1 = t1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one message, wait the N+3 cycle latency, then compare against the queued expectation.
    task automatic run_vec(input vec_t v, input int k);
        vec_t e;
        @(negedge clk);
        st = v.st; d1 = v.d1; d2 = v.d2; rdy = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rdy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL vec%0d scoreboard empty", k);
        end else begin
            e = sb.pop_front();
            chk($sformatf("vec%0d gate0", k), 32'(gate0), 32'(e.gate));
            chk($sformatf("vec%0d trig0", k), 32'(trig0), 32'(e.trig));
            chk($sformatf("vec%0d note0", k), 32'(note0[7*e.v +: 7]), 32'(e.note));
            chk($sformatf("vec%0d vel0", k),  32'(vel0[7*e.v +: 7]),  32'(e.vel));
            chk($sformatf("vec%0d gate1", k), 32'(gate1), 32'(e.gate1));
            chk($sformatf("vec%0d trig1", k), 32'(trig1), 32'(e.trig1));
            chk($sformatf("vec%0d note1", k), 32'(note1[7*e.v +: 7]), 32'(e.note));
            chk($sformatf("vec%0d vel1", k),  32'(vel1[7*e.v +: 7]),  32'(e.vel));
        end
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d trig0 cleared", k), 32'(trig0), 32'd0);
    endtask

    initial begin
        //                  st     d1     d2    gate     trig     v  note vel  gate1    trig1
        vecs[0]  = mk(8'h90, 8'd60, 8'd100, 4'b0001, 4'b0001, 0, 60, 100, 4'b0001, 4'b0001);
        vecs[1]  = mk(8'h90, 8'd64, 8'd80,  4'b0011, 4'b0010, 1, 64, 80,  4'b0011, 4'b0010);
        vecs[2]  = mk(8'h90, 8'd67, 8'd70,  4'b0111, 4'b0100, 2, 67, 70,  4'b0111, 4'b0100);
        vecs[3]  = mk(8'h90, 8'd71, 8'd60,  4'b1111, 4'b1000, 3, 71, 60,  4'b1111, 4'b1000);
        vecs[4]  = mk(8'h90, 8'd72, 8'd50,  4'b1111, 4'b0001, 0, 72, 50,  4'b1111, 4'b0001);
        vecs[5]  = mk(8'h90, 8'd64, 8'd0,   4'b1101, 4'b0000, 1, 64, 80,  4'b1101, 4'b0000);
        vecs[6]  = mk(8'h80, 8'd99, 8'd0,   4'b1101, 4'b0000, 1, 64, 80,  4'b1101, 4'b0000);
        vecs[7]  = mk(8'h91, 8'd60, 8'd100, 4'b1101, 4'b0000, 0, 72, 50,  4'b1111, 4'b0010);
        vecs[8]  = mk(8'h90, 8'd72, 8'd90,  4'b1101, 4'b0001, 0, 72, 90,  4'b1111, 4'b0001);
        vecs[9]  = mk(8'hB0, 8'd123, 8'd0,  4'b0000, 4'b0000, 0, 72, 90,  4'b0000, 4'b0000);
        vecs[10] = mk(8'h90, 8'd50, 8'd40,  4'b0001, 4'b0001, 0, 50, 40,  4'b0001, 4'b0001);
        vecs[11] = mk(8'h80, 8'd50, 8'd0,   4'b0000, 4'b0000, 0, 50, 40,  4'b0000, 4'b0000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset gate0", 32'(gate0), 32'd0);
        chk("reset note0", note0, 32'd0);
        chk("reset vel0",  vel0,  32'd0);
        chk("reset trig0", 32'(trig0), 32'd0);
        chk("reset busy0", 32'(busy0), 32'd0);
        chk("reset ovf0",  32'(ovf0),  32'd0);
        chk("reset gate1", 32'(gate1), 32'd0);
        chk("reset busy1", 32'(busy1), 32'd0);
        chk("reset ovf1",  32'(ovf1),  32'd0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        // Three edges close together: first runs, second waits in pending, third is dropped.
        @(negedge clk); st = 8'h90; d1 = 8'd40; d2 = 8'd10; rdy = 1'b1;
        @(posedge clk);
        @(negedge clk); rdy = 1'b0;
        @(posedge clk);
        @(negedge clk); st = 8'h90; d1 = 8'd41; d2 = 8'd20; rdy = 1'b1;
        @(posedge clk);
        @(negedge clk); rdy = 1'b0;
        @(posedge clk);
        @(negedge clk); st = 8'h90; d1 = 8'd42; d2 = 8'd30; rdy = 1'b1;
        @(posedge clk); #1;
        chk("ovf set on third edge", 32'(ovf0), 32'd1);
        chk("busy during scan", 32'(busy0), 32'd1);
        @(negedge clk); rdy = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("ovf first gate", 32'(gate0), 32'b0001);
        chk("ovf first note", 32'(note0[6:0]), 32'd40);
        repeat (6) @(posedge clk); #1;
        chk("ovf second gate", 32'(gate0), 32'b0011);
        chk("ovf second note", 32'(note0[13:7]), 32'd41);
        chk("ovf second trig", 32'(trig0), 32'b0010);
        repeat (10) @(posedge clk); #1;
        chk("ovf third dropped", 32'(gate0), 32'b0011);
        chk("ovf sticky", 32'(ovf0), 32'd1);
        chk("idle after burst", 32'(busy0), 32'd0);

        // Reset in the middle of a scan must not commit anything.
        @(negedge clk); st = 8'h90; d1 = 8'd30; d2 = 8'd30; rdy = 1'b1;
        @(posedge clk);
        @(negedge clk); rdy = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("busy before abort", 32'(busy0), 32'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        chk("abort busy", 32'(busy0), 32'd0);
        chk("abort ovf cleared", 32'(ovf0), 32'd0);
        chk("abort gate", 32'(gate0), 32'd0);
        chk("abort note", note0, 32'd0);
        repeat (8) @(posedge clk); #1;
        chk("abort no commit gate", 32'(gate0), 32'd0);
        chk("abort no commit note", note0, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
